// File: rtl/soc_pkg.sv
// Shared SoC types for the subordinate OBI port plus manager-arbiter constants.
// Used by obi_mgr_arbiter and obi_arb_idx_fifo.
package soc_pkg;

  typedef struct packed {
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t SbrObiCfg = '{IdWidth: 2};
  localparam int unsigned SbrIdW = SbrObiCfg.IdWidth;

  localparam int unsigned NumArbMgrs  = 2;
  localparam int unsigned ArbMaxTrans = 2;

  typedef enum logic [0:0] {
    ManagInstr = 1'b0,
    ManagData  = 1'b1
  } mgr_idx_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  typedef struct packed {
    logic [31:0]       addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [SbrIdW-1:0] aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
    logic            rready;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]       rdata;
    logic [SbrIdW-1:0] rid;
    logic              err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_arb_idx_fifo.sv
// In-order FIFO of manager indices for outstanding OBI transactions.
// Pushes while full and pops while empty are ignored.
module obi_arb_idx_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/obi_mgr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate port between NumMgr managers.
// Define OBI_MGR_ARBITER_ID_CHECK_EN to build the sticky response-id mismatch check.
//
// state      | meaning
// ARB_IDLE   | candidate picked combinationally from rr_q each cycle
// ARB_LOCKED | a request was not granted; selection held on sel_q until handshake
module obi_mgr_arbiter
  import soc_pkg::*;
#(
  parameter int unsigned NumMgr   = NumArbMgrs,
  parameter int unsigned MaxTrans = ArbMaxTrans
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  sbr_obi_req_t [NumMgr-1:0] mgr_req_i,
  output sbr_obi_rsp_t [NumMgr-1:0] mgr_rsp_o,
  output sbr_obi_req_t              sbr_req_o,
  input  sbr_obi_rsp_t              sbr_rsp_i,
  output logic                      id_mismatch_o
);

  localparam int unsigned IdxW = idx_width(NumMgr);

  if (SbrIdW < IdxW || NumMgr < 2 || NumMgr > 4) begin : g_bad_cfg
    $error("obi_mgr_arbiter: NumMgr must be 2..4 and IdWidth >= clog2(NumMgr)");
  end

  arb_state_e      state_q;
  logic [IdxW-1:0] rr_q, sel_q, cand, sel, head, probe;
  logic            cand_valid, sel_req, fifo_full, fifo_empty, hs, pop;

  // First requesting manager at or after rr_q, wrapping; scan backwards so the nearest wins.
  always_comb begin
    cand       = '0;
    cand_valid = 1'b0;
    probe      = '0;
    for (int i = int'(NumMgr) - 1; i >= 0; i--) begin
      probe = IdxW'((int'(rr_q) + i) % int'(NumMgr));
      if (mgr_req_i[probe].req) begin
        cand       = probe;
        cand_valid = 1'b1;
      end
    end
  end

  assign sel     = (state_q == ARB_LOCKED) ? sel_q : cand;
  assign sel_req = (state_q == ARB_LOCKED) ? mgr_req_i[sel_q].req : cand_valid;

  always_comb begin
    sbr_req_o = '0;
    mgr_rsp_o = '0;
    if (sel_req) begin
      sbr_req_o.a     = mgr_req_i[sel].a;
      sbr_req_o.a.aid = SbrIdW'(sel);
      sbr_req_o.req   = ~fifo_full;
    end
    mgr_rsp_o[sel].gnt = sbr_rsp_i.gnt & sbr_req_o.req;
    sbr_req_o.rready   = fifo_empty ? 1'b1 : mgr_req_i[head].rready;
    if (!fifo_empty && sbr_rsp_i.rvalid) begin
      mgr_rsp_o[head].rvalid = 1'b1;
      mgr_rsp_o[head].r      = sbr_rsp_i.r;
    end
  end

  assign hs  = sbr_req_o.req & sbr_rsp_i.gnt;
  assign pop = sbr_rsp_i.rvalid & sbr_req_o.rready & ~fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
    end else begin
      if (hs) rr_q <= (sel == IdxW'(NumMgr - 1)) ? '0 : sel + 1'b1;
      case (state_q)
        ARB_IDLE: begin
          if (cand_valid && !hs) begin
            state_q <= ARB_LOCKED;
            sel_q   <= cand;
          end
        end
        ARB_LOCKED: begin
          if (hs) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  obi_arb_idx_fifo #(
    .Depth (MaxTrans),
    .Width (IdxW)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .pop_i   (pop),
    .data_i  (sel),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef OBI_MGR_ARBITER_ID_CHECK_EN
  logic id_mismatch_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_mismatch_q <= 1'b0;
    end else if (pop && (sbr_rsp_i.r.rid != SbrIdW'(head))) begin
      id_mismatch_q <= 1'b1;
    end
  end

  assign id_mismatch_o = id_mismatch_q;
`else
  assign id_mismatch_o = 1'b0;
`endif

endmodule

// File: doc/obi_mgr_arbiter.md
Name: obi_mgr_arbiter

Overview:
- Shares one OBI subordinate port (soc_pkg sbr_obi_req_t / sbr_obi_rsp_t) between NumMgr managers, e.g. the instruction and data ports once NumManagers grows beyond 1.
- Round-robin arbitration on the A channel with a lock that holds the selection until grant.
- An in-order index FIFO routes each R-channel response back to the manager that issued the request.
- Sits between the managers and the peripheral crossbar input.

Parameters:
- NumMgr, 2, number of managers; 2..4.
- MaxTrans, 2, maximum outstanding transactions (index FIFO depth); power of 2, at least 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mgr_req_i  in  NumMgr x 73  per-manager sbr_obi_req_t; the incoming aid field is ignored.
- mgr_rsp_o  out  NumMgr x 37  per-manager sbr_obi_rsp_t.
- sbr_req_o  out  73  request to the shared subordinate.
- sbr_rsp_i  in  37  response from the shared subordinate.
- id_mismatch_o  out  1  sticky flag: response rid differs from the expected manager index.

Behaviour:
- **Reset:** rr_q=0, state IDLE, FIFO empty (count 0), id_mismatch_o=0.
- **Idle outputs:** with no requests, sbr_req_o is all-zero and every mgr_rsp_o is all-zero.
- **Arbitration:** the candidate is the first manager with req=1, searching from rr_q upward modulo NumMgr.
- **States:**
  - IDLE: the candidate is selected combinationally. If sbr gnt is not returned in the same cycle, go to LOCKED with sel_q=candidate.
  - LOCKED: the selection is held at sel_q regardless of other requests; return to IDLE on the handshake.
  - OBI forbids withdrawing req, so a LOCKED manager's req stays asserted.
- **Forwarding:**
  - sbr_req_o.a = selected manager's a, with aid replaced by the selected index (truncated to IdWidth).
  - sbr_req_o.req = selected req AND NOT fifo_full.
- **Grant:** mgr_rsp_o[sel].gnt = sbr_rsp_i.gnt AND sbr_req_o.req. All other managers see gnt=0.
- **Handshake** (sbr req and gnt both high):
  - push sel into the FIFO;
  - rr_q <= (sel+1) mod NumMgr;
  - zero added latency on the A channel.
- **R channel:**
  - head = FIFO head index.
  - mgr_rsp_o[head] gets rvalid, rdata, err and rid from sbr_rsp_i; other managers see rvalid=0.
  - sbr_req_o.rready = mgr_req_i[head].rready when the FIFO is non-empty, else 1.
  - Pop on rvalid AND rready.
- **Boundary conditions:**
  - FIFO full: req masked and no grant. No push-while-full, even if a pop happens in the same cycle (one-cycle bubble).
  - Simultaneous push and pop: count unchanged, both pointers advance and wrap modulo MaxTrans.
  - Simultaneous requests from all managers: served in rr order, one per handshake.
  - rvalid while the FIFO is empty: ignored, not routed. This is a protocol error; the bench asserts it never happens.
  - Reset mid-transaction: FIFO cleared; outstanding responses are lost by design. The system resets the subordinate together with the arbiter.
- **Timing:** gnt and rvalid paths are combinational through the arbiter; there are no registered outputs except id_mismatch_o.

Optional Feature:
- Macro: OBI_MGR_ARBITER_ID_CHECK_EN.
- **Defined:** on each pop, compare sbr_rsp_i.rid with head. On mismatch, id_mismatch_o <= 1 and it stays set until reset.
- **Undefined:** id_mismatch_o is tied to 0 and no compare logic is built.
- Response routing is identical in both cases.

Decomposition:
- **soc_pkg:**
  - NumArbMgrs, ArbMaxTrans constants;
  - manager index enum (ManagInstr=0, ManagData=1);
  - SbrObiCfg.IdWidth must be at least clog2(NumMgr), enforced with an elaboration assertion.
- **Reused types:** sbr_obi_req_t / sbr_obi_rsp_t from soc_pkg.
- **Sub-module:** obi_arb_idx_fifo, a parameterized index FIFO (depth MaxTrans, width clog2(NumMgr)) with full/empty outputs and push/pop.

Test Plan:
- Single manager 0 issues a read at 0x1000_0004; subordinate grants immediately, rvalid 2 cycles later with rdata 0xCAFE_F00D.
  - Required: mgr0 gnt in the same cycle; mgr0 rvalid with 0xCAFE_F00D; mgr1 sees rvalid=0; aid=0.
- Both managers request in the same cycle with rr_q=0 and gnt always 1.
  - Required: mgr0 granted in cycle 0 and mgr1 in cycle 1; aids 0 then 1; responses routed in that order.
- Manager 1 requests while the subordinate holds gnt=0 for 3 cycles, and manager 0 raises req in cycle 1.
  - Required: selection stays on mgr1 (LOCKED); mgr1 granted in cycle 3; mgr0 granted next.
- MaxTrans=2, two grants with no rvalid.
  - Required: third request sees sbr req=0 and gnt=0; after one rvalid/rready, the request is granted the following cycle.
- Head manager holds rready=0 for 2 cycles while rvalid=1.
  - Required: sbr rready=0 and no pop; pop occurs when rready=1; FIFO count decrements by exactly 1.
- With OBI_MGR_ARBITER_ID_CHECK_EN defined, subordinate returns rid=1 for mgr0's transaction.
  - Required: id_mismatch_o rises the next cycle and stays 1 until rst_ni is asserted low.
